// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared CPU definitions used by the fetch stage: word width,
//               NOP encoding, default reset PC and the per-cycle fetch action.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // What the fetch stage does in a given cycle, already priority-resolved
    typedef enum logic [1:0] {
        ACT_IDLE     = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_FETCH    = 2'd3
    } if_action_e;

    // Priority: not started > stall > redirect > normal fetch
    function automatic if_action_e decode_action(input logic start,
                                                 input logic stall,
                                                 input logic redirect);
        if_action_e act;
        if (!start) begin
            act = ACT_IDLE;
        end else if (stall) begin
            act = ACT_STALL;
        end else if (redirect) begin
            act = ACT_REDIRECT;
        end else begin
            act = ACT_FETCH;
        end
        return act;
    endfunction

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : CNT_W-bit event counter with increment enable that sticks at
//               all-ones instead of wrapping. Asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count;
    logic             at_max;

    assign at_max  = &count;
    assign count_o = count;

    // Count enabled events, holding once every bit is set
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (inc_i && !at_max) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch stage. Owns the PC register, next-PC mux and
//               IF/ID pipeline register; counts applied stalls and flushes.
//               Instruction memory is read combinationally at the PC.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  target_i,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic [XLEN-1:0]  imem_data_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  ifid_instr_o,
    output logic [XLEN-1:0]  ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] ifid_pc4;
    logic            ifid_valid;
    if_action_e      action;
    logic            stall_event;
    logic            flush_event;

    // Wraps modulo 2^32 naturally; no carry is kept
    assign pc_plus4       = pc + PC_STEP;
    // Low target bits are dropped so the PC stays word aligned
    assign target_aligned = target_i & ~32'h0000_0003;

    assign action      = decode_action(start_i, stall_i, redirect_i);
    assign stall_event = (action == ACT_STALL);
    assign flush_event = (action == ACT_REDIRECT);

    // Next-PC selection from the resolved per-cycle action
    always_comb begin
        next_pc = pc;
        case (action)
            ACT_FETCH:    next_pc = pc_plus4;
            ACT_REDIRECT: next_pc = target_aligned;
            default:      next_pc = pc;
        endcase
    end

    // PC register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // IF/ID register: load fetched word, insert bubble, or hold on stall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifid_instr <= NOP_WORD;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            case (action)
                ACT_FETCH: begin
                    ifid_instr <= imem_data_i;
                    ifid_pc4   <= pc_plus4;
                    ifid_valid <= 1'b1;
                end
                ACT_STALL: begin
                    ifid_instr <= ifid_instr;
                    ifid_pc4   <= ifid_pc4;
                    ifid_valid <= ifid_valid;
                end
                default: begin
                    ifid_instr <= NOP_WORD;
                    ifid_pc4   <= '0;
                    ifid_valid <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (stall_event),
        .count_o (stall_cnt_o)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (flush_event),
        .count_o (flush_cnt_o)
    );

    assign pc_o         = pc;
    assign imem_addr_o  = pc;
    assign ifid_instr_o = ifid_instr;
    assign ifid_pc4_o   = ifid_pc4;
    assign ifid_valid_o = ifid_valid;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage: behavioural reference model
//               compared every cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             start    = 1'b0;
    logic             stall    = 1'b0;
    logic             redirect = 1'b0;
    logic [31:0]      target   = 32'h0;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic [31:0]      pc;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc4;
    logic             ifid_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .target_i     (target),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .pc_o         (pc),
        .ifid_instr_o (ifid_instr),
        .ifid_pc4_o   (ifid_pc4),
        .ifid_valid_o (ifid_valid),
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1111_0000 + addr;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of the architectural state
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4   = 32'h0;
    logic        m_valid = 1'b0;
    int          m_stall = 0;
    int          m_flush = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
            m_stall <= 0;  m_flush <= 0;
        end else if (!start) begin
            m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
        end else if (stall) begin
            m_stall <= (m_stall < MAXC) ? m_stall + 1 : MAXC;
        end else if (redirect) begin
            m_pc    <= {target[31:2], 2'b00};
            m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
            m_flush <= (m_flush < MAXC) ? m_flush + 1 : MAXC;
        end else begin
            m_instr <= mem_word(m_pc);
            m_pc4   <= m_pc + 32'd4;
            m_pc    <= m_pc + 32'd4;
            m_valid <= 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("model.pc",        pc,                m_pc);
        check("model.imem_addr", imem_addr,         m_pc);
        check("model.instr",     ifid_instr,        m_instr);
        check("model.pc4",       ifid_pc4,          m_pc4);
        check("model.valid",     32'(ifid_valid),   32'(m_valid));
        check("model.stall_cnt", 32'(stall_cnt),    32'(m_stall));
        check("model.flush_cnt", 32'(flush_cnt),    32'(m_flush));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        step();
        step();
        check("reset.pc",    pc,                32'h0);
        check("reset.valid", 32'(ifid_valid),   32'h0);
        check("reset.cnts",  32'({stall_cnt, flush_cnt}), 32'h0);

        // Release reset and fetch straight away
        rst = 1'b0; start = 1'b1;
        step();
        check("run.pc1",    pc,              32'h4);
        check("run.instr1", ifid_instr,      32'h1111_0000);
        check("run.valid1", 32'(ifid_valid), 32'h1);
        step();
        check("run.pc2",    pc,              32'h8);
        check("run.instr2", ifid_instr,      32'h1111_0004);
        check("run.pc4_2",  ifid_pc4,        32'h8);

        // Two-cycle stall at PC=8
        stall = 1'b1;
        step(); step();
        check("stall.pc",    pc,             32'h8);
        check("stall.instr", ifid_instr,     32'h1111_0004);
        check("stall.cnt",   32'(stall_cnt), 32'h2);
        stall = 1'b0;
        step();
        check("resume.pc",    pc,         32'hC);
        check("resume.instr", ifid_instr, 32'h1111_0008);

        // Redirect with unaligned target
        redirect = 1'b1; target = 32'h43;
        step();
        check("redir.pc",    pc,              32'h40);
        check("redir.valid", 32'(ifid_valid), 32'h0);
        check("redir.instr", ifid_instr,      32'h0);
        check("redir.flush", 32'(flush_cnt),  32'h1);

        // Stall wins over redirect
        stall = 1'b1;
        step();
        check("both.pc",    pc,             32'h40);
        check("both.stall", 32'(stall_cnt), 32'h3);
        check("both.flush", 32'(flush_cnt), 32'h1);
        stall = 1'b0; redirect = 1'b0;
        step();
        check("after.pc", pc, 32'h44);

        // PC wrap at the top of the address space
        redirect = 1'b1; target = 32'hFFFF_FFFE;
        step();
        check("wrap.pc_top", pc, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        check("wrap.pc",    pc,         32'h0);
        check("wrap.instr", ifid_instr, 32'h1110_FFFC);
        check("wrap.pc4",   ifid_pc4,   32'h0);

        // Saturate both counters
        stall = 1'b1;
        repeat (14) step();
        check("sat.stall", 32'(stall_cnt), MAXC);
        check("sat.pc",    pc,             32'h0);
        stall = 1'b0; redirect = 1'b1; target = 32'h100;
        repeat (14) step();
        check("sat.flush", 32'(flush_cnt), MAXC);
        redirect = 1'b0;

        // Reset pulsed mid-period while running
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async.pc",    pc,              32'h0);
        check("async.instr", ifid_instr,      32'h0);
        check("async.pc4",   ifid_pc4,        32'h0);
        check("async.valid", 32'(ifid_valid), 32'h0);
        check("async.cnts",  32'({stall_cnt, flush_cnt}), 32'h0);
        #1 rst = 1'b0;
        step();
        check("post_rst.pc", pc, 32'h4);
        step();
        stall = 1'b1;
        step();
        check("idle_pre.stall", 32'(stall_cnt), 32'h1);

        // Idle for three cycles: frozen PC, bubbles, counters held
        start = 1'b0;
        repeat (3) step();
        check("idle.pc",    pc,              32'h8);
        check("idle.valid", 32'(ifid_valid), 32'h0);
        check("idle.instr", ifid_instr,      32'h0);
        check("idle.stall", 32'(stall_cnt),  32'h1);
        check("idle.flush", 32'(flush_cnt),  32'h0);
        start = 1'b1; stall = 1'b0;
        step();
        check("restart.pc",    pc,         32'hC);
        check("restart.instr", ifid_instr, 32'h1111_0008);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire
